sr04_ctrl: RTL and testbench

Measurement controller for the HC-SR04 ultrasonic ranging path.
- Sequences one measurement: trigger pulse, wait for echo, time the echo, convert to centimetres, then holdoff.
- Supports single-shot requests (button/FSM pulse) and optional free-running auto mode.
- Sits between the watch's mode FSM and the SR04 pins; the display/FND path consumes `o_dist`.

---
 rtl/sr04_ctrl_if.sv | 23 ++
 rtl/sr04_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sr04_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr04_ctrl_if.sv
// Pin/handshake bundle between the mode FSM side (master) and the SR04 measurement controller (slave).
// Carries the 1 us tick, measurement requests, raw echo pin and the controller's result outputs.
interface sr04_ctrl_if;
    logic       i_tick;
    logic       i_start;
    logic       i_auto;
    logic       i_echo;
    logic       o_trig;
    logic [8:0] o_dist;
    logic       o_done;
    logic       o_err;
    logic       o_busy;

    modport master (
        output i_tick, i_start, i_auto, i_echo,
        input  o_trig, o_dist, o_done, o_err, o_busy
    );

    modport slave (
        input  i_tick, i_start, i_auto, i_echo,
        output o_trig, o_dist, o_done, o_err, o_busy
    );
endinterface

// File: rtl/sr04_ctrl.sv
// HC-SR04 measurement sequencer: trigger, echo wait, echo timing to cm, holdoff.
// Define SR04_AUTO_EN to let a held i_auto launch back-to-back measurements.
module sr04_ctrl #(
    parameter int TRIG_US     = 10,
    parameter int US_PER_CM   = 58,
    parameter int WAIT_TO_US  = 30000,
    parameter int MAX_ECHO_US = 25000,
    parameter int HOLDOFF_US  = 60000
) (
    input  logic        clk,
    input  logic        rst,
    sr04_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } state_t;

    // Limits are compared against the pre-increment count on a tick cycle.
    localparam logic [15:0] TRIG_LAST    = 16'(TRIG_US - 1);
    localparam logic [15:0] WAIT_LAST    = 16'(WAIT_TO_US - 1);
    localparam logic [15:0] ECHO_LAST    = 16'(MAX_ECHO_US - 1);
    localparam logic [15:0] HOLDOFF_LAST = 16'(HOLDOFF_US - 1);
    localparam logic [15:0] CM_LAST      = 16'(US_PER_CM - 1);
    localparam logic [8:0]  CM_MAX       = 9'd511;

    state_t      state_reg;
    logic [15:0] us_cnt_reg;
    logic [15:0] sub_reg;
    logic [15:0] sub_next;
    logic [8:0]  cm_reg;
    logic [8:0]  cm_next;
    logic [2:0]  echo_sync_reg;
    logic        trig_reg;
    logic [8:0]  dist_reg;
    logic        done_reg;
    logic        err_reg;
    logic        busy_reg;
    logic        echo_rise;
    logic        echo_fall;
    logic        go;

    // Two synchronizer flops, third copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_sync_reg <= 3'b000;
        end else begin
            echo_sync_reg <= {echo_sync_reg[1:0], bus.i_echo};
        end
    end

    assign echo_rise = echo_sync_reg[1] & ~echo_sync_reg[2];
    assign echo_fall = ~echo_sync_reg[1] & echo_sync_reg[2];

`ifdef SR04_AUTO_EN
    assign go = bus.i_start | bus.i_auto;
`else
    logic unused_auto;
    assign go          = bus.i_start;
    assign unused_auto = bus.i_auto;
`endif

    // cm_next includes the tick of the current cycle so a fall on a tick edge is not short by one.
    always_comb begin
        sub_next = sub_reg;
        cm_next  = cm_reg;
        if (bus.i_tick) begin
            if (sub_reg == CM_LAST) begin
                sub_next = 16'd0;
                if (cm_reg != CM_MAX) begin
                    cm_next = cm_reg + 9'd1;
                end
            end else begin
                sub_next = sub_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            us_cnt_reg <= 16'd0;
            sub_reg    <= 16'd0;
            cm_reg     <= 9'd0;
            trig_reg   <= 1'b0;
            dist_reg   <= 9'd0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (bus.i_tick) begin
                us_cnt_reg <= us_cnt_reg + 16'd1;
            end
            case (state_reg)
                IDLE: begin
                    us_cnt_reg <= 16'd0;
                    if (go) begin
                        state_reg <= TRIG;
                        trig_reg  <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                TRIG: begin
                    if (bus.i_tick && us_cnt_reg == TRIG_LAST) begin
                        state_reg  <= WAIT_ECHO;
                        trig_reg   <= 1'b0;
                        us_cnt_reg <= 16'd0;
                    end
                end
                WAIT_ECHO: begin
                    sub_reg <= 16'd0;
                    cm_reg  <= 9'd0;
                    // Only a fresh rise counts; an echo already high leaves echo_rise low.
                    if (echo_rise) begin
                        state_reg  <= MEASURE;
                        us_cnt_reg <= 16'd0;
                    end else if (bus.i_tick && us_cnt_reg == WAIT_LAST) begin
                        state_reg  <= HOLDOFF;
                        err_reg    <= 1'b1;
                        us_cnt_reg <= 16'd0;
                    end
                end
                MEASURE: begin
                    sub_reg <= sub_next;
                    cm_reg  <= cm_next;
                    if (echo_fall) begin
                        state_reg  <= HOLDOFF;
                        dist_reg   <= cm_next;
                        done_reg   <= 1'b1;
                        err_reg    <= 1'b0;
                        us_cnt_reg <= 16'd0;
                    end else if (bus.i_tick && us_cnt_reg == ECHO_LAST) begin
                        state_reg  <= HOLDOFF;
                        err_reg    <= 1'b1;
                        us_cnt_reg <= 16'd0;
                    end
                end
                HOLDOFF: begin
                    if (bus.i_tick && us_cnt_reg == HOLDOFF_LAST) begin
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                        us_cnt_reg <= 16'd0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    trig_reg   <= 1'b0;
                    busy_reg   <= 1'b0;
                    us_cnt_reg <= 16'd0;
                end
            endcase
        end
    end

    assign bus.o_trig = trig_reg;
    assign bus.o_dist = dist_reg;
    assign bus.o_done = done_reg;
    assign bus.o_err  = err_reg;
    assign bus.o_busy = busy_reg;

endmodule

// File: tb/tb_sr04_ctrl.sv
// Directed + randomized bench for sr04_ctrl against a distance/error reference model.
// Time base is compressed (short tick period and reduced limits) to keep the run short.
`timescale 1ns/1ps
module tb_sr04_ctrl;

    localparam int DIV         = 2;
    localparam int TRIG_US     = 10;
    localparam int US_PER_CM   = 58;
    localparam int WAIT_TO_US  = 400;
    localparam int MAX_ECHO_US = 1500;
    localparam int HOLDOFF_US  = 600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   tick_phase = 0;
    int   tick_total = 0;
    int   exp_dist = 0;
    int   exp_err = 0;

    sr04_ctrl_if bus ();

    sr04_ctrl #(
        .TRIG_US    (TRIG_US),
        .US_PER_CM  (US_PER_CM),
        .WAIT_TO_US (WAIT_TO_US),
        .MAX_ECHO_US(MAX_ECHO_US),
        .HOLDOFF_US (HOLDOFF_US)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Tick changes just after a rising edge, so it is stable when sampled at the falling edge.
    always @(posedge clk) begin
        #1;
        tick_phase = (tick_phase == DIV - 1) ? 0 : tick_phase + 1;
        bus.i_tick = (tick_phase == 0);
        if (bus.i_tick) tick_total++;
    end

    always @(negedge clk) begin
        if (bus.o_done === 1'b1) done_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic count_trig(output int ticks);
        int g = 0;
        ticks = 0;
        while (bus.o_trig === 1'b1 && g < 5000) begin
            if (bus.i_tick) ticks++;
            @(negedge clk);
            g++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (bus.o_busy !== 1'b0 && g < 20000) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_idle"}, bus.o_busy, 0);
    endtask

    task automatic run_meas(input int delay_t, input int echo_t, input bit poke, input string tag);
        int d0;
        int tw;
        bit ok;
        d0 = done_cnt;
        pulse_start();
        check({tag, "_trig_rise"}, bus.o_trig, 1);
        count_trig(tw);
        check({tag, "_trig_ticks"}, tw, TRIG_US);
        clk_n(delay_t * DIV);
        if (echo_t > 0) begin
            bus.i_echo = 1'b1;
            for (int i = 0; i < echo_t * DIV; i++) begin
                bus.i_start = (poke && (i % 50 == 7));
                @(negedge clk);
            end
            bus.i_start = 1'b0;
            bus.i_echo  = 1'b0;
        end
        wait_idle(tag);
        ok = (echo_t > 0) && (echo_t < MAX_ECHO_US);
        if (ok) begin
            exp_err  = 0;
            exp_dist = (echo_t / US_PER_CM > 511) ? 511 : echo_t / US_PER_CM;
        end else begin
            exp_err = 1;
        end
        check({tag, "_dist"}, bus.o_dist, exp_dist);
        check({tag, "_err"}, bus.o_err, exp_err);
        check({tag, "_done_count"}, done_cnt - d0, ok ? 1 : 0);
        $display("meas %s delay=%0d echo=%0d dist=%0d err=%0d", tag, delay_t, echo_t, bus.o_dist, bus.o_err);
    endtask

    initial begin
        int d0;
        int tw;
        int g;
        int n;
        int prev_t;
        bus.i_start = 1'b0;
        bus.i_auto  = 1'b0;
        bus.i_echo  = 1'b0;

        // Reset state and echo activity while idle.
        clk_n(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_trig", bus.o_trig, 0);
        check("rst_dist", bus.o_dist, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_err", bus.o_err, 0);
        check("rst_busy", bus.o_busy, 0);
        bus.i_echo = 1'b1;
        clk_n(20);
        bus.i_echo = 1'b0;
        clk_n(10);
        check("idle_echo_busy", bus.o_busy, 0);
        check("idle_echo_dist", bus.o_dist, 0);
        check("idle_echo_done", done_cnt, 0);
        $display("reset checks done");

        run_meas(200, 1160, 1'b0, "single");

        // No echo: timeout in WAIT_ECHO, then a full holdoff with busy held.
        d0 = done_cnt;
        pulse_start();
        count_trig(tw);
        check("noecho_trig_ticks", tw, TRIG_US);
        tw = 0;
        g = 0;
        while (bus.o_err === 1'b0 && bus.o_busy === 1'b1 && g < 5000) begin
            if (bus.i_tick) tw++;
            @(negedge clk);
            g++;
        end
        check("noecho_wait_ticks", tw, WAIT_TO_US);
        check("noecho_err", bus.o_err, 1);
        check("noecho_dist_kept", bus.o_dist, exp_dist);
        tw = 0;
        g = 0;
        while (bus.o_busy === 1'b1 && g < 5000) begin
            if (bus.i_tick) tw++;
            @(negedge clk);
            g++;
        end
        check("noecho_holdoff_ticks", tw, HOLDOFF_US);
        check("noecho_done_count", done_cnt - d0, 0);
        exp_err = 1;
        $display("meas noecho err=%0d dist=%0d", bus.o_err, bus.o_dist);

        run_meas(100, MAX_ECHO_US + 200, 1'b0, "too_long");
        run_meas(50, 57, 1'b0, "echo57");
        run_meas(50, 58, 1'b0, "echo58");
        run_meas(50, 300, 1'b1, "busy_poke");
        clk_n(20);
        check("busy_poke_not_queued", bus.o_busy, 0);

        // Reset during TRIG aborts at once.
        d0 = done_cnt;
        pulse_start();
        check("abort_trig_rise", bus.o_trig, 1);
        clk_n(3);
        rst = 1'b1;
        @(negedge clk);
        check("abort_trig", bus.o_trig, 0);
        check("abort_busy", bus.o_busy, 0);
        @(negedge clk);
        check("abort_dist", bus.o_dist, 0);
        rst = 1'b0;
        exp_dist = 0;
        exp_err  = 0;
        clk_n(20);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_idle", bus.o_busy, 0);
        $display("reset abort dist=%0d busy=%0d", bus.o_dist, bus.o_busy);

        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 4) == 0) n = $urandom_range(MAX_ECHO_US + 5, MAX_ECHO_US + 200);
            else n = $urandom_range(1, MAX_ECHO_US - 5);
            run_meas($urandom_range(1, 300), n, 1'b0, $sformatf("rand%0d", k));
        end

`ifdef SR04_AUTO_EN
        bus.i_auto = 1'b1;
        prev_t = 0;
        for (int k = 0; k < 3; k++) begin
            g = 0;
            while (bus.o_trig !== 1'b1 && g < 5000) begin
                @(negedge clk);
                g++;
            end
            check("auto_trig_seen", bus.o_trig, 1);
            if (k > 0) check("auto_spacing_ok", (tick_total - prev_t) >= HOLDOFF_US, 1);
            prev_t = tick_total;
            d0 = done_cnt;
            count_trig(tw);
            clk_n(50 * DIV);
            bus.i_echo = 1'b1;
            clk_n(580 * DIV);
            bus.i_echo = 1'b0;
            g = 0;
            while (done_cnt == d0 && g < 100) begin
                @(negedge clk);
                g++;
            end
            check("auto_done", done_cnt - d0, 1);
            check("auto_dist", bus.o_dist, 10);
            $display("auto meas %0d dist=%0d", k, bus.o_dist);
        end
        bus.i_auto = 1'b0;
        wait_idle("auto_end");
`else
        bus.i_auto = 1'b1;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.o_trig === 1'b1) n++;
        end
        bus.i_auto = 1'b0;
        check("auto_disabled_trig", n, 0);
        check("auto_disabled_busy", bus.o_busy, 0);
        $display("auto disabled trig_cycles=%0d", n);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
